// File: rtl/int_controller.sv
// rtl/int_controller.sv - 8-source + NMI interrupt controller with single in-service slot and EOI release.
// Optional INT_SYNC_EN macro inserts 2-flop input synchronisers ahead of edge detection.
module int_controller #(
    parameter logic [7:0] MASK_RST = 8'hFF,
    parameter logic [7:0] EDGE_RST = 8'h00
) (
    input  logic       clk,
    input  logic       a_rst,
    input  logic [7:0] src,
    input  logic       nmi_src,
    input  logic       int_ack,
    output logic       nmi,
    output logic       irq,
    output logic [2:0] int_id,
    input  logic       reg_we,
    input  logic [1:0] reg_addr,
    input  logic [7:0] reg_wdata,
    output logic [7:0] reg_rdata
);

    localparam logic [1:0] ADDR_MASK   = 2'd0;
    localparam logic [1:0] ADDR_EDGE   = 2'd1;
    localparam logic [1:0] ADDR_PEND   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    logic [8:0] s;
    logic [8:0] s_q, s_d;
    logic [8:0] rise;

    logic [7:0] mask_q, mask_d;
    logic [7:0] edge_sel_q, edge_sel_d;
    logic [7:0] pend_q, pend_d;
    logic       nmi_pend_q, nmi_pend_d;
    logic       isr_v_q, isr_v_d;
    logic [2:0] isr_id_q, isr_id_d;
    logic       nmi_q, nmi_d;
    logic       irq_q, irq_d;
    logic [7:0] reg_rdata_q, reg_rdata_d;

    logic [7:0] active;
    logic       ack_nmi;
    logic       ack_irq;
    logic       eoi;
    logic       pend_wr;
    logic [7:0] ack_clr;
    logic [7:0] clr;

`ifdef INT_SYNC_EN
    logic [8:0] sync1_q, sync1_d;
    logic [8:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = {nmi_src, src};
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            sync1_q <= 9'd0;
            sync2_q <= 9'd0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign s = sync2_q;
`else
    assign s = {nmi_src, src};
`endif

    assign s_d  = s;
    assign rise = s & ~s_q;

    // Lowest-index unmasked pending source wins.
    always_comb begin
        active = pend_q & ~mask_q;
        int_id = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (active[i]) begin
                int_id = i[2:0];
            end
        end
    end

    // NMI always takes the ack first; the IRQ path only sees acks NMI left alone.
    always_comb begin
        ack_nmi = int_ack & nmi_pend_q;
        ack_irq = int_ack & ~nmi_pend_q & irq_q;
        eoi     = reg_we && (reg_addr == ADDR_STATUS);
        pend_wr = reg_we && (reg_addr == ADDR_PEND);
        ack_clr = 8'd0;
        if (ack_irq && edge_sel_q[int_id]) begin
            ack_clr = 8'd1 << int_id;
        end
        clr = ack_clr | (pend_wr ? reg_wdata : 8'd0);
    end

    always_comb begin
        mask_d     = mask_q;
        edge_sel_d = edge_sel_q;
        if (reg_we && (reg_addr == ADDR_MASK)) begin
            mask_d = reg_wdata;
        end
        if (reg_we && (reg_addr == ADDR_EDGE)) begin
            edge_sel_d = reg_wdata;
        end
    end

    // Edge pending survives only while the bit was, and stays, edge-triggered; a new edge beats any clear.
    always_comb begin
        pend_d = 8'd0;
        for (int i = 0; i < 8; i++) begin
            if (!edge_sel_d[i]) begin
                pend_d[i] = s[i];
            end else begin
                pend_d[i] = rise[i] | (pend_q[i] & edge_sel_q[i] & ~clr[i]);
            end
        end
    end

    always_comb begin
        nmi_pend_d = rise[8] | (nmi_pend_q & ~ack_nmi);
        isr_v_d    = isr_v_q;
        isr_id_d   = isr_id_q;
        if (ack_irq) begin
            isr_v_d  = 1'b1;
            isr_id_d = int_id;
        end else if (eoi) begin
            isr_v_d  = 1'b0;
        end
    end

    always_comb begin
        nmi_d = nmi_pend_q;
        irq_d = (|active) & ~isr_v_q;
    end

    always_comb begin
        reg_rdata_d = 8'd0;
        case (reg_addr)
            ADDR_MASK:   reg_rdata_d = mask_q;
            ADDR_EDGE:   reg_rdata_d = edge_sel_q;
            ADDR_PEND:   reg_rdata_d = pend_q;
            ADDR_STATUS: reg_rdata_d = {nmi_pend_q, isr_v_q, 3'b000, isr_id_q};
            default:     reg_rdata_d = 8'd0;
        endcase
    end

    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            s_q         <= 9'd0;
            mask_q      <= MASK_RST;
            edge_sel_q  <= EDGE_RST;
            pend_q      <= 8'd0;
            nmi_pend_q  <= 1'b0;
            isr_v_q     <= 1'b0;
            isr_id_q    <= 3'd0;
            nmi_q       <= 1'b0;
            irq_q       <= 1'b0;
            reg_rdata_q <= 8'd0;
        end else begin
            s_q         <= s_d;
            mask_q      <= mask_d;
            edge_sel_q  <= edge_sel_d;
            pend_q      <= pend_d;
            nmi_pend_q  <= nmi_pend_d;
            isr_v_q     <= isr_v_d;
            isr_id_q    <= isr_id_d;
            nmi_q       <= nmi_d;
            irq_q       <= irq_d;
            reg_rdata_q <= reg_rdata_d;
        end
    end

    assign nmi       = nmi_q;
    assign irq       = irq_q;
    assign reg_rdata = reg_rdata_q;

endmodule

// File: tb/tb_int_controller.sv
// tb/tb_int_controller.sv - directed self-checking bench for int_controller.
module tb_int_controller;

`ifdef INT_SYNC_EN
    localparam int EX  = 2;
`else
    localparam int EX  = 0;
`endif
    localparam int LAT = 2 + EX;

    logic       clk = 1'b0;
    logic       a_rst = 1'b0;
    logic [7:0] src = 8'd0;
    logic       nmi_src = 1'b0;
    logic       int_ack = 1'b0;
    logic       nmi;
    logic       irq;
    logic [2:0] int_id;
    logic       reg_we = 1'b0;
    logic [1:0] reg_addr = 2'd0;
    logic [7:0] reg_wdata = 8'd0;
    logic [7:0] reg_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    int n;
    logic [7:0] rv;

    int_controller dut (
        .clk       (clk),
        .a_rst     (a_rst),
        .src       (src),
        .nmi_src   (nmi_src),
        .int_ack   (int_ack),
        .nmi       (nmi),
        .irq       (irq),
        .int_id    (int_id),
        .reg_we    (reg_we),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        reg_we    = 1'b1;
        reg_addr  = a;
        reg_wdata = d;
        step();
        reg_we    = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] d);
        reg_addr = a;
        step();
        d = reg_rdata;
    endtask

    task automatic ack();
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
    endtask

    // Pulse leaves the pending bit set by the time it returns.
    task automatic pulse_src(input logic [7:0] b);
        src = src | b;
        step();
        src = src & ~b;
        repeat (EX) step();
    endtask

    task automatic pulse_nmi();
        nmi_src = 1'b1;
        step();
        nmi_src = 1'b0;
        repeat (EX) step();
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_nmi", {7'd0, nmi}, 8'd0);
        check("rst_irq", {7'd0, irq}, 8'd0);
        check("rst_rdata", reg_rdata, 8'd0);
        #2 a_rst = 1'b1;
        step();
        rd(2'd0, rv); check("rst_mask", rv, 8'hFF);
        rd(2'd1, rv); check("rst_edge", rv, 8'h00);

        // Level source 0, ack, EOI with source still high
        wr(2'd0, 8'hFE);
        src[0] = 1'b1;
        n = 0;
        while (irq !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        check("lvl_latency", n[7:0], LAT[7:0]);
        check("lvl_id", {5'd0, int_id}, 8'd0);
        ack();
        step();
        check("lvl_ack_irq", {7'd0, irq}, 8'd0);
        rd(2'd3, rv); check("lvl_status", rv, 8'h40);
        wr(2'd3, 8'h00);
        step();
        check("lvl_eoi_irq", {7'd0, irq}, 8'd1);
        src[0] = 1'b0;
        repeat (4 + EX) step();
        check("lvl_drop_irq", {7'd0, irq}, 8'd0);

        // Two simultaneous edges on sources 2 and 3
        wr(2'd1, 8'h0C);
        wr(2'd0, 8'h00);
        pulse_src(8'h0C);
        check("edge_id2", {5'd0, int_id}, 8'd2);
        step();
        check("edge_irq", {7'd0, irq}, 8'd1);
        ack();
        rd(2'd2, rv); check("edge_pend", rv, 8'h08);
        check("edge_ack_irq", {7'd0, irq}, 8'd0);
        wr(2'd3, 8'h00);
        step();
        check("edge_eoi_irq", {7'd0, irq}, 8'd1);
        check("edge_id3", {5'd0, int_id}, 8'd3);

        // NMI while irq is pending
        pulse_nmi();
        step();
        check("nmi_set", {7'd0, nmi}, 8'd1);
        ack();
        step();
        check("nmi_ack_nmi", {7'd0, nmi}, 8'd0);
        check("nmi_ack_irq", {7'd0, irq}, 8'd1);
        rd(2'd3, rv); check("nmi_status", rv, 8'h02);

        // New NMI edge in the same cycle as the NMI ack
        pulse_nmi();
        step();
        check("nmi2_set", {7'd0, nmi}, 8'd1);
        nmi_src = 1'b1;
        repeat (EX) step();
        ack();
        nmi_src = 1'b0;
        step();
        check("nmi2_keep", {7'd0, nmi}, 8'd1);
        rd(2'd3, rv); check("nmi2_status", rv, 8'h82);
        ack();
        repeat (2) step();
        check("nmi2_clear", {7'd0, nmi}, 8'd0);

        // PEND write clears edge pending; concurrent new edge wins
        wr(2'd1, 8'h2C);
        wr(2'd2, 8'h08);
        pulse_src(8'h20);
        step();
        rd(2'd2, rv); check("pw_pend_set", rv, 8'h20);
        check("pw_irq_set", {7'd0, irq}, 8'd1);
        wr(2'd2, 8'h20);
        rd(2'd2, rv); check("pw_pend_clr", rv, 8'h00);
        check("pw_irq_clr", {7'd0, irq}, 8'd0);
        pulse_src(8'h20);
        step();
        src[5] = 1'b1;
        repeat (EX) step();
        wr(2'd2, 8'h20);
        src[5] = 1'b0;
        rd(2'd2, rv); check("pw_race_pend", rv, 8'h20);
        check("pw_race_irq", {7'd0, irq}, 8'd1);

        // Asynchronous reset with an interrupt in service and NMI raised
        ack();
        pulse_nmi();
        step();
        rd(2'd3, rv); check("ar_status", rv, 8'hC5);
        check("ar_nmi_pre", {7'd0, nmi}, 8'd1);
        #2 a_rst = 1'b0;
        #1;
        check("ar_nmi", {7'd0, nmi}, 8'd0);
        check("ar_irq", {7'd0, irq}, 8'd0);
        check("ar_rdata", reg_rdata, 8'd0);
        #3 a_rst = 1'b1;
        step();
        rd(2'd3, rv); check("ar_status_post", rv, 8'h00);
        rd(2'd2, rv); check("ar_pend_post", rv, 8'h00);
        rd(2'd0, rv); check("ar_mask_post", rv, 8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
